// File: rtl/dt_vote_accum_if.sv
// rtl/dt_vote_accum_if.sv - classifier-result input and vote-result output handshake bundle
interface dt_vote_accum_if #(
    parameter int CNT_W = 8
);
    logic             in_valid;
    logic [2:0]       in_class;
    logic             in_ready;
    logic             out_valid;
    logic [2:0]       out_class;
    logic [CNT_W-1:0] out_count;
    logic             out_ready;

    modport master (
        output in_valid, in_class, out_ready,
        input  in_ready, out_valid, out_class, out_count
    );

    modport slave (
        input  in_valid, in_class, out_ready,
        output in_ready, out_valid, out_class, out_count
    );
endinterface

// File: rtl/dt_vote_accum.sv
// rtl/dt_vote_accum.sv - majority vote over WINDOW decision-tree class results
// Optional macro DT_VOTE_TIE_HIGH_EN: highest tied class index wins instead of lowest.
module dt_vote_accum #(
    parameter int WINDOW = 16,
    parameter int CNT_W  = 8
) (
    input  logic            clk,
    input  logic            rst,
    dt_vote_accum_if.slave  bus
);
    localparam logic [1:0] ACCUM = 2'd0;
    localparam logic [1:0] SCAN  = 2'd1;
    localparam logic [1:0] HOLD  = 2'd2;

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt [8];
    logic [CNT_W-1:0] win_cnt;
    logic [3:0]       scan_idx;
    logic [2:0]       best_cls;
    logic [CNT_W-1:0] best_cnt;
    logic             ready_r;
    logic             valid_r;
    logic [2:0]       class_r;
    logic [CNT_W-1:0] count_r;

    logic             accept;
    logic             last;
    logic [CNT_W-1:0] scan_cnt;
    logic             take;

    assign accept   = bus.in_valid && ready_r;
    assign last     = accept && (win_cnt == CNT_W'(WINDOW - 1));
    assign scan_cnt = cnt[scan_idx[2:0]];

`ifdef DT_VOTE_TIE_HIGH_EN
    assign take = (scan_cnt >= best_cnt);
`else
    assign take = (scan_cnt > best_cnt);
`endif

    assign bus.in_ready  = ready_r;
    assign bus.out_valid = valid_r;
    assign bus.out_class = class_r;
    assign bus.out_count = count_r;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ACCUM;
            for (int i = 0; i < 8; i++) cnt[i] <= '0;
            win_cnt  <= '0;
            scan_idx <= '0;
            best_cls <= '0;
            best_cnt <= '0;
            ready_r  <= 1'b0;
            valid_r  <= 1'b0;
            class_r  <= '0;
            count_r  <= '0;
        end else begin
            case (state)
                ACCUM: begin
                    // ready rises on the first edge after reset and drops with the window's last sample
                    ready_r <= !last;
                    if (accept) begin
                        cnt[bus.in_class] <= cnt[bus.in_class] + CNT_W'(1);
                        win_cnt           <= win_cnt + CNT_W'(1);
                    end
                    if (last) begin
                        state    <= SCAN;
                        scan_idx <= '0;
                        best_cls <= '0;
                        best_cnt <= '0;
                    end
                end
                SCAN: begin
                    // indices 0..7 examine one class each; index 8 commits, giving a 9-cycle latency
                    if (scan_idx == 4'd8) begin
                        class_r <= best_cls;
                        count_r <= best_cnt;
                        valid_r <= 1'b1;
                        state   <= HOLD;
                    end else begin
                        if (take) begin
                            best_cls <= scan_idx[2:0];
                            best_cnt <= scan_cnt;
                        end
                        scan_idx <= scan_idx + 4'd1;
                    end
                end
                HOLD: begin
                    if (valid_r && bus.out_ready) begin
                        for (int i = 0; i < 8; i++) cnt[i] <= '0;
                        win_cnt <= '0;
                        valid_r <= 1'b0;
                        ready_r <= 1'b1;
                        state   <= ACCUM;
                    end
                end
                default: begin
                    state   <= ACCUM;
                    ready_r <= 1'b0;
                    valid_r <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_dt_vote_accum.sv
// tb/tb_dt_vote_accum.sv - directed vector bench for dt_vote_accum (WINDOW=16 and WINDOW=2)
module tb_dt_vote_accum;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dt_vote_accum_if #(.CNT_W(8)) b16 ();
    dt_vote_accum_if #(.CNT_W(8)) b2 ();

    dt_vote_accum #(.WINDOW(16), .CNT_W(8)) u16 (.clk(clk), .rst(rst), .bus(b16.slave));
    dt_vote_accum #(.WINDOW(2),  .CNT_W(8)) u2  (.clk(clk), .rst(rst), .bus(b2.slave));

    int checks = 0;
    int errors = 0;

    typedef struct {
        int na; int ca; int nb; int cb; int ec; int en;
    } vec_t;
    vec_t vecs [5];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic rdy(input int sel);
        return (sel == 2) ? b2.in_ready : b16.in_ready;
    endfunction
    function automatic logic ovld(input int sel);
        return (sel == 2) ? b2.out_valid : b16.out_valid;
    endfunction
    function automatic int ocls(input int sel);
        return (sel == 2) ? int'(b2.out_class) : int'(b16.out_class);
    endfunction
    function automatic int ocnt(input int sel);
        return (sel == 2) ? int'(b2.out_count) : int'(b16.out_count);
    endfunction

    task automatic drive_in(input int sel, input logic v, input logic [2:0] c);
        if (sel == 2) begin b2.in_valid = v; b2.in_class = c; end
        else begin b16.in_valid = v; b16.in_class = c; end
    endtask
    task automatic drive_ord(input int sel, input logic r);
        if (sel == 2) b2.out_ready = r; else b16.out_ready = r;
    endtask

    // present one sample and return just after the edge that accepts it
    task automatic send(input int sel, input logic [2:0] c);
        int b = 0;
        @(negedge clk);
        drive_in(sel, 1'b1, c);
        while (!rdy(sel) && b < 100) begin
            @(negedge clk);
            b++;
        end
        if (b >= 100) chk("send_timeout", 1, 0);
        @(posedge clk);
        #1;
        drive_in(sel, 1'b0, 3'd0);
    endtask

    task automatic wait_result(input int sel, output int lat);
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (!ovld(sel) && lat < 40);
        if (!ovld(sel)) chk("result_timeout", 0, 1);
    endtask

    task automatic consume(input int sel);
        @(negedge clk);
        drive_ord(sel, 1'b1);
        @(posedge clk);
        #1;
        drive_ord(sel, 1'b0);
        chk("consume_valid_low", int'(ovld(sel)), 0);
        chk("consume_ready_high", int'(rdy(sel)), 1);
    endtask

    initial begin
        int lat;
        int hc, hn;
        int hold_bad;

        b16.in_valid = 0; b16.in_class = 0; b16.out_ready = 0;
        b2.in_valid = 0;  b2.in_class = 0;  b2.out_ready = 0;

        vecs[0] = '{na:10, ca:5, nb:6,  cb:2, ec:5, en:10};
`ifdef DT_VOTE_TIE_HIGH_EN
        vecs[1] = '{na:8,  ca:1, nb:8,  cb:6, ec:6, en:8};
        vecs[4] = '{na:8,  ca:4, nb:8,  cb:0, ec:4, en:8};
`else
        vecs[1] = '{na:8,  ca:1, nb:8,  cb:6, ec:1, en:8};
        vecs[4] = '{na:8,  ca:4, nb:8,  cb:0, ec:0, en:8};
`endif
        vecs[2] = '{na:16, ca:7, nb:0,  cb:0, ec:7, en:16};
        vecs[3] = '{na:4,  ca:0, nb:12, cb:3, ec:3, en:12};

        // reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", int'(b16.in_ready), 0);
        chk("rst_out_valid", int'(b16.out_valid), 0);
        chk("rst_out_class", int'(b16.out_class), 0);
        chk("rst_out_count", int'(b16.out_count), 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("post_rst_in_ready", int'(b16.in_ready), 1);

        // table-driven windows on WINDOW=16
        for (int v = 0; v < 5; v++) begin
            for (int k = 0; k < vecs[v].na; k++) send(16, 3'(vecs[v].ca));
            for (int k = 0; k < vecs[v].nb; k++) send(16, 3'(vecs[v].cb));
            chk($sformatf("v%0d_ready_low", v), int'(b16.in_ready), 0);
            wait_result(16, lat);
            chk($sformatf("v%0d_latency", v), lat, 9);
            chk($sformatf("v%0d_class", v), ocls(16), vecs[v].ec);
            chk($sformatf("v%0d_count", v), ocnt(16), vecs[v].en);
            consume(16);
        end

        // held result with out_ready low and in_valid high for 20 cycles
        for (int k = 0; k < 16; k++) send(16, 3'd5);
        wait_result(16, lat);
        hc = ocls(16);
        hn = ocnt(16);
        chk("hold_class", hc, 5);
        chk("hold_count", hn, 16);
        @(negedge clk);
        b16.in_valid = 1'b1;
        b16.in_class = 3'd4;
        hold_bad = 0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk);
            #1;
            if (!b16.out_valid || b16.in_ready || ocls(16) != 5 || ocnt(16) != 16) hold_bad++;
        end
        chk("hold_stable", hold_bad, 0);
        b16.in_valid = 1'b0;
        consume(16);
        for (int k = 0; k < 16; k++) send(16, 3'd2);
        wait_result(16, lat);
        chk("after_hold_class", ocls(16), 2);
        chk("after_hold_count", ocnt(16), 16);
        consume(16);

        // reset mid-window abandons the partial count
        for (int k = 0; k < 7; k++) send(16, 3'd5);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrst_in_ready", int'(b16.in_ready), 0);
        @(negedge clk);
        rst = 1'b0;
        hold_bad = 0;
        for (int k = 0; k < 15; k++) begin
            @(posedge clk);
            #1;
            if (b16.out_valid) hold_bad++;
        end
        chk("midrst_no_result", hold_bad, 0);
        for (int k = 0; k < 16; k++) send(16, 3'd3);
        wait_result(16, lat);
        chk("midrst_class", ocls(16), 3);
        chk("midrst_count", ocnt(16), 16);
        consume(16);

        // random gaps between accepted samples
        for (int k = 0; k < 16; k++) begin
            int gap = $urandom_range(0, 3);
            for (int g = 0; g < gap; g++) begin
                @(negedge clk);
                b16.in_valid = 1'b0;
            end
            send(16, 3'd0);
        end
        wait_result(16, lat);
        chk("gap_latency", lat, 9);
        chk("gap_class", ocls(16), 0);
        chk("gap_count", ocnt(16), 16);
        consume(16);

        // WINDOW=2 back-to-back windows, 7 then 4
        for (int w = 0; w < 2; w++) begin
            send(2, 3'd7);
            send(2, 3'd4);
            wait_result(2, lat);
            chk($sformatf("w2_%0d_latency", w), lat, 9);
`ifdef DT_VOTE_TIE_HIGH_EN
            chk($sformatf("w2_%0d_class", w), ocls(2), 7);
`else
            chk($sformatf("w2_%0d_class", w), ocls(2), 4);
`endif
            chk($sformatf("w2_%0d_count", w), ocnt(2), 1);
            consume(2);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got 1 expected 0");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/dt_vote_accum.md
DT_VOTE_ACCUM -- requirements
Module: dt_vote_accum

Interface
REQ-001 SHALL have parameter WINDOW, default 16, giving the number of classifier results per vote (legal range 2..255).
REQ-002 SHALL have parameter CNT_W, default 8, giving the per-class counter width (must satisfy 2^CNT_W > WINDOW).
REQ-003 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-005 SHALL have port in_valid  input  1  a 3-bit class result from the upstream decision-tree classifier is present.
REQ-006 SHALL have port in_class  input  3  class code, 0..7.
REQ-007 SHALL have port in_ready  output  1  block accepts in_class this cycle.
REQ-008 SHALL have port out_valid  output  1  a vote result is held.
REQ-009 SHALL have port out_class  output  3  majority class of the completed window.
REQ-010 SHALL have port out_count  output  CNT_W  number of window samples that matched out_class.
REQ-011 SHALL have port out_ready  input  1  downstream consumes the result.

Function
REQ-012 SHALL use three states: ACCUM, SCAN, HOLD.
REQ-013 SHALL accept a sample only when in_valid=1 and in_ready=1; in_ready=1 only in ACCUM.
REQ-014 SHALL, on each accepted sample, increment counter[in_class] by 1 and the window counter by 1.
REQ-015 SHALL move ACCUM->SCAN on the cycle the WINDOW-th sample is accepted; in_ready deasserts the following cycle.
REQ-016 SHALL, in SCAN, examine one class per cycle in index order 0..7 (8 cycles), tracking best class and best count.
REQ-017 SHALL replace the best only on strictly greater count (default tie rule: lowest index wins).
REQ-018 SHALL move SCAN->HOLD after class 7 is examined, registering out_class/out_count and asserting out_valid the same edge.
REQ-019 SHALL provide a fixed latency of 9 cycles from the edge accepting the WINDOW-th sample to out_valid=1.
REQ-020 SHALL hold out_valid, out_class, out_count stable in HOLD until out_valid=1 and out_ready=1.
REQ-021 SHALL, on that handshake, clear all 8 class counters and the window counter, deassert out_valid, and enter ACCUM (in_ready=1 next cycle).
REQ-022 SHALL ignore in_valid while in SCAN or HOLD (no counter changes, samples dropped upstream by handshake).
REQ-023 SHALL never wrap any counter: by REQ-002 a count cannot exceed WINDOW.
REQ-024 SHALL treat in_class values as unsigned 3-bit; all 8 codes are legal.

Reset
REQ-025 SHALL, while rst=1, force state ACCUM, all counters 0, out_valid=0, out_class=0, out_count=0, in_ready=0.
REQ-026 SHALL assert in_ready=1 the first clock edge after rst deasserts.
REQ-027 SHALL abandon any partial window, scan, or held result on reset mid-operation; no result is emitted for it.

Configuration
REQ-028 SHALL support macro DT_VOTE_TIE_HIGH_EN.
REQ-029 SHALL, with DT_VOTE_TIE_HIGH_EN defined, replace the best on greater-or-equal count so the highest tied index wins.
REQ-030 SHALL, without DT_VOTE_TIE_HIGH_EN, apply REQ-017 (lowest tied index wins); no other behaviour differs.

Verification
REQ-031 SHALL cover: WINDOW=16, 10x class 5 + 6x class 2, out_ready=1 -> out_class=5, out_count=10, out_valid 9 cycles after last accept.
REQ-032 SHALL cover: WINDOW=16, 8x class 1 + 8x class 6 -> out_class=1, out_count=8 without macro; out_class=6, out_count=8 with DT_VOTE_TIE_HIGH_EN.
REQ-033 SHALL cover: result held with out_ready=0 for 20 cycles while in_valid=1 -> outputs stable, in_ready=0, no counter change; after handshake next window starts from zero.
REQ-034 SHALL cover: rst pulsed after 7 accepted samples -> no out_valid; next 16 samples of class 3 -> out_class=3, out_count=16.
REQ-035 SHALL cover: in_valid toggling randomly, 16 accepted samples all class 0 -> out_class=0, out_count=16 regardless of gaps.
REQ-036 SHALL cover: WINDOW=2, classes 7 then 4, back-to-back windows -> results (4,1) without macro, (7,1) with macro, each consumed by one-cycle out_ready.
